// File: rtl/bram1_port_ctrl_pkg.sv
// Shared types and helpers for the single-port BRAM request controller.
// Optional build macro (used by the top level): BRAM1_PORT_CTRL_WRACK_EN.
package bram1_port_ctrl_pkg;

    // One in-flight slot: a BRAM access that has been issued but whose
    // response has not yet reached the response FIFO.
    typedef struct packed {
        logic vld;
        logic is_wr;
    } inflight_tag_t;

    // Ceiling log2 with a floor of 1 bit, used to size counters and pointers.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/bram1_port_ctrl_rsp_fifo.sv
// Response FIFO, RESP_DEPTH x DATA_WIDTH, for bram1_port_ctrl.
// The caller never pushes when full nor pops when empty; count, full and
// empty are provided for the credit logic.
module bram1_port_ctrl_rsp_fifo
    import bram1_port_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int RESP_DEPTH = 4,
    parameter int CNT_W      = clog2(RESP_DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = clog2(RESP_DEPTH);

    logic [DATA_WIDTH-1:0] mem [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Pointer advance with wrap, so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage array: written on push, deliberately not reset.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy; push and pop on the same edge leave count unchanged.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CNT_W'(RESP_DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/bram1_port_ctrl.sv
// Request-side controller for a single-ported BRAM with 1- or 2-cycle read
// latency. Drives the BRAM pins for each accepted request, tags the access
// through a LAT-deep shift register, captures DO in the right cycle and
// returns read data in order through a response FIFO.
// Build macro BRAM1_PORT_CTRL_WRACK_EN: when defined, writes hold a credit
// and return a zero-data acknowledge in the read-latency slot; otherwise
// writes are fire-and-forget.
module bram1_port_ctrl
    import bram1_port_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int PIPELINED  = 0,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_di,
    input  logic [DATA_WIDTH-1:0] bram_do
);

    localparam int LAT   = 1 + PIPELINED;
    localparam int CNT_W = clog2(RESP_DEPTH + 1);
    localparam int INF_W = clog2(LAT + 1);
    localparam int OCC_W = CNT_W + 1;

`ifdef BRAM1_PORT_CTRL_WRACK_EN
    localparam logic WRACK = 1'b1;
`else
    localparam logic WRACK = 1'b0;
`endif

    inflight_tag_t         tag_p [LAT];
    logic                  rst_done_q;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [INF_W-1:0]      inflight;
    logic [OCC_W-1:0]      occupancy;
    logic [DATA_WIDTH-1:0] push_data;

    // Credits in use: responses waiting in the FIFO plus tagged accesses still in the BRAM.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) inflight = inflight + INF_W'(tag_p[i].vld);
        occupancy = OCC_W'(fifo_count) + OCC_W'(inflight);
    end

    // Ready is built only from registered state, so it never loops back to valid/ready inputs.
    assign req_ready = rst_done_q & ~fifo_full & (occupancy < OCC_W'(RESP_DEPTH));
    assign accept    = req_valid & req_ready;

    assign bram_en   = accept;
    assign bram_we   = accept & req_write;
    assign bram_addr = req_addr;
    assign bram_di   = req_data;

    // Ready stays low until the first clock edge after reset is released.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rst_done_q <= 1'b0;
        else        rst_done_q <= 1'b1;
    end

    // In-flight tags: stage 0 loaded on accept, last stage marks the cycle DO is valid.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < LAT; i++) tag_p[i] <= '0;
        end else begin
            tag_p[0].vld   <= accept & (WRACK | ~req_write);
            tag_p[0].is_wr <= accept & req_write;
            for (int i = 1; i < LAT; i++) tag_p[i] <= tag_p[i-1];
        end
    end

    // DO is only captured in tagged cycles; write acknowledges carry zero data.
    assign push      = tag_p[LAT-1].vld;
    assign push_data = tag_p[LAT-1].is_wr ? '0 : bram_do;
    assign rsp_valid = ~fifo_empty;
    assign pop       = ~fifo_empty & rsp_ready;

    bram1_port_ctrl_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESP_DEPTH (RESP_DEPTH),
        .CNT_W      (CNT_W)
    ) u_rsp_fifo (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .pop_data   (rsp_data),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

endmodule

// File: tb/tb_bram1_port_ctrl.sv
// Scoreboard bench for bram1_port_ctrl: one instance at read latency 1 and
// one at read latency 2, each attached to a behavioural BRAM.
module tb_bram1_port_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 200;

`ifdef BRAM1_PORT_CTRL_WRACK_EN
    localparam bit WRACK = 1'b1;
`else
    localparam bit WRACK = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        bit            chk_lat;
        int            exp_cyc;
    } exp_t;

    logic          CLK   = 1'b0;
    logic          RST_N = 1'b1;
    logic          req_valid [2];
    logic          req_ready [2];
    logic          req_write [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_data  [2];
    logic          rsp_valid [2];
    logic          rsp_ready [2];
    logic [DW-1:0] rsp_data  [2];
    logic          bram_en   [2];
    logic          bram_we   [2];
    logic [AW-1:0] bram_addr [2];
    logic [DW-1:0] bram_di   [2];
    logic [DW-1:0] bram_do   [2];

    logic [DW-1:0] mem0 [16];
    logic [DW-1:0] mem1 [16];
    logic [DW-1:0] do0_r, do1_r, do1_p;
    logic [DW-1:0] refm [2][16];

    exp_t exp_q [2][$];
    exp_t mon_e;
    int   cyc    = 0;
    int   vecs   = 0;
    int   errs   = 0;
    int   acc    = 0;
    int   stalls = 0;
    bit   rnd_on = 1'b0;

    bram1_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(0), .RESP_DEPTH(DEPTH)) u_l1 (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_data(req_data[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
        .bram_en(bram_en[0]), .bram_we(bram_we[0]), .bram_addr(bram_addr[0]),
        .bram_di(bram_di[0]), .bram_do(bram_do[0])
    );

    bram1_port_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIPELINED(1), .RESP_DEPTH(DEPTH)) u_l2 (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_data(req_data[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
        .bram_en(bram_en[1]), .bram_we(bram_we[1]), .bram_addr(bram_addr[1]),
        .bram_di(bram_di[1]), .bram_do(bram_do[1])
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural BRAMs (read-first); the latency-2 one adds an output register.
    always @(posedge CLK) begin
        if (bram_en[0]) begin
            if (bram_we[0]) mem0[bram_addr[0]] <= bram_di[0];
            do0_r <= mem0[bram_addr[0]];
        end
        if (bram_en[1]) begin
            if (bram_we[1]) mem1[bram_addr[1]] <= bram_di[1];
            do1_r <= mem1[bram_addr[1]];
        end
        do1_p <= do1_r;
    end
    assign bram_do[0] = do0_r;
    assign bram_do[1] = do1_p;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Present one request until accepted, then push its expected response.
    task automatic do_req(input int u, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW-1:0] exp_d, input bit chk_l, input bit want);
        int   n;
        bit   got;
        exp_t e;
        n   = 0;
        got = 1'b0;
        req_valid[u] = 1'b1;
        req_write[u] = wr;
        req_addr[u]  = a;
        req_data[u]  = d;
        while (!got && n < TMO) begin
            @(negedge CLK);
            if (req_ready[u]) got = 1'b1;
            else begin
                stalls++;
                n++;
                chk("bram_en_idle", 32'(bram_en[u]), 32'd0);
            end
        end
        if (!got) chk("req_accept_timeout", 32'd0, 32'd1);
        else begin
            acc++;
            chk("bram_pins", 32'({bram_en[u], bram_we[u], bram_addr[u], bram_di[u]}),
                32'({1'b1, wr, a, d}));
            e.chk_lat = chk_l;
            e.exp_cyc = cyc + u + 2;
            e.data    = exp_d;
            if (wr) begin
                refm[u][a] = d;
                if (WRACK) begin
                    e.data = '0;
                    exp_q[u].push_back(e);
                end
            end else if (want) begin
                exp_q[u].push_back(e);
            end
            chk("credit_bound", 32'(exp_q[u].size() <= DEPTH), 32'd1);
        end
        @(posedge CLK);
        #1;
        req_valid[u] = 1'b0;
    endtask

    task automatic drain(input int u);
        int n;
        n = 0;
        while (exp_q[u].size() != 0 && n < TMO * 4) begin
            @(posedge CLK);
            n++;
        end
        repeat (4) @(posedge CLK);
        #1;
        chk("drain_empty", exp_q[u].size(), 32'd0);
    endtask

    // Monitor: every response handshake pops and checks the oldest expectation.
    always @(negedge CLK) begin
        if (RST_N) begin
            for (int u = 0; u < 2; u++) begin
                if (rsp_valid[u] && rsp_ready[u]) begin
                    if (exp_q[u].size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                    else begin
                        mon_e = exp_q[u].pop_front();
                        chk("rsp_data", 32'(rsp_data[u]), 32'(mon_e.data));
                        if (mon_e.chk_lat) chk("rsp_latency", cyc, mon_e.exp_cyc);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            idle;
        int            s0;

        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b1;
            req_write[u] = 1'b0;
            req_addr[u]  = '0;
            req_data[u]  = '0;
            rsp_ready[u] = 1'b1;
        end
        #1 RST_N = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            for (int u = 0; u < 2; u++) begin
                chk("reset_req_ready", 32'(req_ready[u]), 32'd0);
                chk("reset_rsp_valid", 32'(rsp_valid[u]), 32'd0);
                chk("reset_bram_en", 32'(bram_en[u]), 32'd0);
            end
        end
        @(posedge CLK);
        #1;
        RST_N        = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        @(posedge CLK);
        #1;

        // Latency 1: write 0xA5 to 3 then read 3, back to back.
        s0 = stalls;
        do_req(0, 1'b1, 4'd3, 8'hA5, 8'h00, 1'b1, 1'b1);
        do_req(0, 1'b0, 4'd3, 8'h00, 8'hA5, 1'b1, 1'b1);
        chk("t1_consecutive", stalls - s0, 32'd0);
        drain(0);

        // Preload latency-2 BRAM: addr i holds 0x10+i.
        for (int i = 0; i < 16; i++) do_req(1, 1'b1, 4'(i), 8'(16 + i), 8'h00, 1'b1, 1'b1);
        drain(1);

        // Latency 2: 8 back-to-back reads, no stalls, first response at accept+3.
        s0 = stalls;
        for (int i = 0; i < 8; i++) do_req(1, 1'b0, 4'(i), 8'h00, 8'(16 + i), 1'b1, 1'b1);
        chk("t2_no_stall", stalls - s0, 32'd0);
        drain(1);

        // Response back-pressure: only DEPTH reads fit until responses drain.
        rsp_ready[1] = 1'b0;
        acc = 0;
        fork
            for (int i = 0; i < 6; i++) do_req(1, 1'b0, 4'(8 + i), 8'h00, 8'(24 + i), 1'b0, 1'b1);
            begin
                repeat (12) @(negedge CLK);
                chk("t3_accepted_when_full", acc, DEPTH);
                chk("t3_ready_low", 32'(req_ready[1]), 32'd0);
                @(posedge CLK);
                #1;
                rsp_ready[1] = 1'b1;
            end
        join
        chk("t3_accepted_all", acc, 32'd6);
        drain(1);

        // Reset while a read is in flight: it must never return.
        do_req(1, 1'b0, 4'd2, 8'h00, 8'h00, 1'b0, 1'b0);
        RST_N        = 1'b0;
        req_valid[1] = 1'b1;
        @(negedge CLK);
        chk("t4_ready_in_reset", 32'(req_ready[1]), 32'd0);
        chk("t4_en_in_reset", 32'(bram_en[1]), 32'd0);
        @(posedge CLK);
        #1;
        RST_N        = 1'b1;
        req_valid[1] = 1'b0;
        @(negedge CLK);
        chk("t4_ready_at_release", 32'(req_ready[1]), 32'd0);
        @(negedge CLK);
        chk("t4_ready_after_release", 32'(req_ready[1]), 32'd1);
        repeat (6) begin
            @(negedge CLK);
            chk("t4_no_rsp", 32'(rsp_valid[1]), 32'd0);
        end
        @(posedge CLK);
        #1;

        // Alternating write/read to addr 5: reads see the value just written.
        for (int k = 0; k < 4; k++) begin
            do_req(1, 1'b1, 4'd5, 8'(80 + 7 * k), 8'h00, 1'b1, 1'b1);
            do_req(1, 1'b0, 4'd5, 8'h00, 8'(80 + 7 * k), 1'b1, 1'b1);
        end
        drain(1);

        // Random traffic with throttled valid and ready against the reference memory.
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge CLK);
                    #1;
                    rsp_ready[1] = ($urandom_range(0, 3) != 0);
                end
            end
            begin
                for (int k = 0; k < 2000; k++) begin
                    wr = ($urandom_range(0, 2) == 0);
                    a  = 4'($urandom_range(0, 15));
                    d  = 8'($urandom_range(0, 255));
                    do_req(1, wr, a, d, refm[1][a], 1'b0, 1'b1);
                    idle = $urandom_range(0, 2);
                    if (idle != 0) begin
                        repeat (idle) @(posedge CLK);
                        #1;
                    end
                end
                rnd_on = 1'b0;
            end
        join
        rsp_ready[1] = 1'b1;
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
